// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin nibble arbiter.
// Optional grant-extend feature is enabled by defining MUX_ARB_LOCK_EN.
package mux_arb_pkg;

    localparam int NUM_REQ         = 4;
    localparam int NIB_W           = 4;
    localparam int SEL_W           = 2;
    localparam int HOLD_CYCLES_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/multiplexer.sv
// 4:1 nibble multiplexer with enable; output is zero when disabled.
module multiplexer
    import mux_arb_pkg::*;
(
    input  logic                     en,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_REQ*NIB_W-1:0] d,
    output logic [NIB_W-1:0]         y
);

    always_comb begin
        y = en ? d[{sel, 2'b00} +: NIB_W] : '0;
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Walk from the farthest candidate back to ptr so the nearest hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered nibble channel among four requesters.
// Define MUX_ARB_LOCK_EN to add the lock port that extends a grant past HOLD_CYCLES.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*NIB_W-1:0] data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [SEL_W-1:0]         sel,
    output logic                     busy,
    output logic [NIB_W-1:0]         Y,
    output logic                     valid
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NIB_W-1:0] y_q, y_d;
    logic             valid_q, valid_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [NIB_W-1:0] mux_y;
    logic             hold_at_zero;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    multiplexer u_mux (
        .en  (busy),
        .sel (sel_q),
        .d   (data),
        .y   (mux_y)
    );

`ifdef MUX_ARB_LOCK_EN
    assign hold_at_zero = lock[sel_q];
`else
    assign hold_at_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    ptr_d   = pick_idx + SEL_W'(1);
                end
            end
            ST_GRANT: begin
                y_d     = mux_y;
                valid_d = 1'b1;
                // Dropping the owner's request always releases, even when locked.
                if (!req[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!hold_at_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = (state_q == ST_GRANT);
    assign gnt   = busy ? onehot(sel_q) : '0;
    assign sel   = sel_q;
    assign Y     = y_q;
    assign valid = valid_q;

endmodule
